// File: rtl/alu16_sequencer.sv
// alu16_sequencer
//
// Runs the 16-bit operations ADD HL,rr / ADD SP,e8 / INC rr / DEC rr on the
// shared 8-bit add-with-carry ALU as two byte passes: the low byte first,
// then the high byte with the low-byte carry-out fed back as carry-in.
// The block owns the ALU operand muxes only while busy. At all other times
// the control decoder drives them.
//
// Parameters
//   ALU_LAT     cycles from ALU operand presentation to valid result and
//               carries (1..4). Each byte phase lasts exactly ALU_LAT cycles.
//
// Optional feature
//   ALU16_SEQ_ABORT_EN  when defined, adds the 'abort' input. It cancels a
//                       running operation in the LO or HI phase.
//
// Ports
//   clk        in   rising-edge clock
//   nreset     in   synchronous active-low reset
//   start      in   request, accepted only while idle
//   op         in   00 ADD16, 01 ADDSP, 10 INC16, 11 DEC16 (sampled at accept)
//   opa        in   operand A (sampled at accept)
//   opb        in   operand B, ADDSP uses opb[7:0] as signed e8 (sampled at accept)
//   abort      in   (ALU16_SEQ_ABORT_EN only) cancel the running operation
//   busy       out  sequencer owns the ALU
//   done       out  one-cycle pulse, result/flags valid
//   result     out  16-bit result, held until the next completion
//   flags      out  {Z,N,H,C}
//   flags_we   out  per-flag write enable {Z,N,H,C}, qualified by done
//   alu_en     out  ALU operand mux select
//   alu_a      out  ALU operand A
//   alu_b      out  ALU operand B
//   alu_cin    out  ALU carry-in
//   alu_res    in   ALU sum
//   alu_cout   in   ALU carry out of bit 7
//   alu_hout   in   ALU carry out of bit 3
module alu16_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
`ifdef ALU16_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  flags_we,
  output logic        alu_en,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_ADDSP = 2'b01;
  localparam logic [1:0] OP_INC16 = 2'b10;
  localparam logic [1:0] OP_DEC16 = 2'b11;

  // Phase counter value on the last cycle of a byte phase.
  localparam logic [1:0] PH_LAST = 2'(ALU_LAT - 1);

  // ALU operand B byte for a given op and byte phase.
  // INC16 adds 0 with a carry-in of 1. DEC16 adds 0xFFFF, which is -1.
  function automatic logic [7:0] b_byte(input logic [1:0]  op_v,
                                        input logic [15:0] b_v,
                                        input logic        hi_v);
    logic [7:0] r;
    case (op_v)
      OP_ADD16: r = hi_v ? b_v[15:8] : b_v[7:0];
      OP_ADDSP: r = hi_v ? {8{b_v[7]}} : b_v[7:0];
      OP_INC16: r = 8'h00;
      OP_DEC16: r = 8'hFF;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  op_q;
  logic [15:0] opa_q, opb_q;
  logic [7:0]  lo_sum_q, hi_sum_q;
  logic        lo_c_q, lo_h_q, hi_c_q, hi_h_q;
  logic        busy_q, done_q, alu_en_q, alu_cin_q;
  logic [7:0]  alu_a_q, alu_b_q;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  flags_we_q, flags_we_d;
  logic        abort_s;
  logic        phase_last_s;

`ifdef ALU16_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign phase_last_s = (cnt_q == PH_LAST);

  // Next-state logic. Abort only acts in LO/HI. In IDLE it is ignored,
  // and while busy a start is already ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (phase_last_s) begin
          state_d = S_HI;
        end else begin
          state_d = S_LO;
        end
      end
      S_HI: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (phase_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, phase counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != S_IDLE);
      alu_en_q <= (state_d == S_LO) || (state_d == S_HI);
      // done appears together with the committed result, one cycle after DONE.
      done_q   <= (state_q == S_DONE);
      if (state_d != state_q) begin
        cnt_q <= 2'd0;
      end else if ((state_q == S_LO) || (state_q == S_HI)) begin
        cnt_q <= cnt_q + 2'd1;
      end else begin
        cnt_q <= 2'd0;
      end
    end
  end

  // Operand latch at accept, per-phase ALU drive and end-of-phase captures.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      op_q      <= 2'd0;
      opa_q     <= 16'h0000;
      opb_q     <= 16'h0000;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_cin_q <= 1'b0;
      lo_sum_q  <= 8'h00;
      lo_c_q    <= 1'b0;
      lo_h_q    <= 1'b0;
      hi_sum_q  <= 8'h00;
      hi_c_q    <= 1'b0;
      hi_h_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_LO) begin
            op_q      <= op;
            opa_q     <= opa;
            opb_q     <= opb;
            alu_a_q   <= opa[7:0];
            alu_b_q   <= b_byte(op, opb, 1'b0);
            alu_cin_q <= (op == OP_INC16);
          end
        end
        S_LO: begin
          if (state_d == S_HI) begin
            lo_sum_q  <= alu_res;
            lo_c_q    <= alu_cout;
            lo_h_q    <= alu_hout;
            alu_a_q   <= opa_q[15:8];
            alu_b_q   <= b_byte(op_q, opb_q, 1'b1);
            // The live carry-out is the same value being captured into lo_c_q.
            alu_cin_q <= alu_cout;
          end
        end
        S_HI: begin
          if (state_d == S_DONE) begin
            hi_sum_q <= alu_res;
            hi_c_q   <= alu_cout;
            hi_h_q   <= alu_hout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and flag update, applied only on the DONE cycle.
  always_comb begin
    result_d   = result_q;
    flags_d    = flags_q;
    flags_we_d = flags_we_q;
    if (state_q == S_DONE) begin
      result_d = {hi_sum_q, lo_sum_q};
      case (op_q)
        OP_ADD16: begin
          flags_we_d = 4'b0111;
          flags_d    = {flags_q[3], 1'b0, hi_h_q, hi_c_q};
        end
        OP_ADDSP: begin
          flags_we_d = 4'b1111;
          flags_d    = {1'b0, 1'b0, lo_h_q, lo_c_q};
        end
        default: begin
          // INC16/DEC16 leave every flag untouched.
          flags_we_d = 4'b0000;
          flags_d    = flags_q;
        end
      endcase
    end else begin
      result_d   = result_q;
      flags_d    = flags_q;
      flags_we_d = flags_we_q;
    end
  end

  // Result/flag registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      result_q   <= 16'h0000;
      flags_q    <= 4'h0;
      flags_we_q <= 4'h0;
    end else begin
      result_q   <= result_d;
      flags_q    <= flags_d;
      flags_we_q <= flags_we_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign flags_we = flags_we_q;
  assign alu_en   = alu_en_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer. Two instances run side by side,
// at ALU_LAT=1 and ALU_LAT=3. Each has its own pipelined 8-bit adder model
// and a behavioural reference model, which computes results with plain
// 16-bit arithmetic.
module tb_alu16_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic        nreset_a [2];
  logic        start_a  [2];
  logic [1:0]  op_a     [2];
  logic [15:0] opa_a    [2];
  logic [15:0] opb_a    [2];
  logic        busy_a   [2];
  logic        done_a   [2];
  logic        alu_en_a [2];
  logic [15:0] result_a [2];
  logic [3:0]  flags_a  [2];
  logic [3:0]  fwe_a    [2];
  logic [16:0] aluop_a  [2];
  bit          chk_en_a [2];

  task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL [LAT=%0d] %s: got %h, expected %h (t=%0t)", lat, nm, act, exp, $time);
    end
  endtask

  // Reference: returns {result[15:0], flags[3:0], flags_we[3:0]}.
  function automatic logic [23:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] prev);
    logic [16:0] s;
    logic [12:0] h12;
    logic [8:0]  c8;
    logic [4:0]  h4;
    logic [3:0]  f;
    logic [3:0]  we;
    case (op)
      2'b00: begin
        s   = {1'b0, a} + {1'b0, b};
        h12 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
        f   = {prev[3], 1'b0, h12[12], s[16]};
        we  = 4'b0111;
      end
      2'b01: begin
        s  = {1'b0, a} + {1'b0, {8{b[7]}}, b[7:0]};
        c8 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        h4 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        f  = {1'b0, 1'b0, h4[4], c8[8]};
        we = 4'b1111;
      end
      2'b10: begin
        s  = {1'b0, a} + 17'd1;
        f  = prev;
        we = 4'b0000;
      end
      default: begin
        s  = {1'b0, a} + 17'h0FFFF;
        f  = prev;
        we = 4'b0000;
      end
    endcase
    return {s[15:0], f, we};
  endfunction

  // Expected ALU drive {a, b, cin} for a phase.
  function automatic logic [16:0] exp_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic hi);
    logic [15:0] b16;
    logic        cin0;
    logic [8:0]  lo;
    case (op)
      2'b00:   begin b16 = b;                      cin0 = 1'b0; end
      2'b01:   begin b16 = {{8{b[7]}}, b[7:0]};    cin0 = 1'b0; end
      2'b10:   begin b16 = 16'h0000;               cin0 = 1'b1; end
      default: begin b16 = 16'hFFFF;               cin0 = 1'b0; end
    endcase
    lo = {1'b0, a[7:0]} + {1'b0, b16[7:0]} + {8'd0, cin0};
    return hi ? {a[15:8], b16[15:8], lo[8]} : {a[7:0], b16[7:0], cin0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

    logic        busy_s, done_s, alu_en_s, alu_cin_s, alu_cout_s, alu_hout_s;
    logic [15:0] result_s;
    logic [3:0]  flags_s, fwe_s;
    logic [7:0]  alu_a_s, alu_b_s, alu_res_s;

    alu16_sequencer #(.ALU_LAT(LAT)) u_dut (
      .clk(clk), .nreset(nreset_a[g]), .start(start_a[g]), .op(op_a[g]),
      .opa(opa_a[g]), .opb(opb_a[g]), .busy(busy_s), .done(done_s),
      .result(result_s), .flags(flags_s), .flags_we(fwe_s), .alu_en(alu_en_s),
      .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_cin(alu_cin_s),
      .alu_res(alu_res_s), .alu_cout(alu_cout_s), .alu_hout(alu_hout_s)
    );

    assign busy_a[g]   = busy_s;
    assign done_a[g]   = done_s;
    assign alu_en_a[g] = alu_en_s;
    assign result_a[g] = result_s;
    assign flags_a[g]  = flags_s;
    assign fwe_a[g]    = fwe_s;
    assign aluop_a[g]  = {alu_a_s, alu_b_s, alu_cin_s};

    // Adder model: combinational sum delayed by LAT-1 register stages.
    logic [8:0] sum9;
    logic [4:0] nib5;
    logic [9:0] now_s;
    logic [9:0] pipe_q [4];
    always_comb begin
      sum9  = {1'b0, alu_a_s} + {1'b0, alu_b_s} + {8'd0, alu_cin_s};
      nib5  = {1'b0, alu_a_s[3:0]} + {1'b0, alu_b_s[3:0]} + {4'd0, alu_cin_s};
      now_s = {nib5[4], sum9[8], sum9[7:0]};
    end
    always @(posedge clk) begin
      pipe_q[0] <= now_s;
      for (int i = 1; i < 4; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign {alu_hout_s, alu_cout_s, alu_res_s} = (LAT == 1) ? now_s : pipe_q[PI];

    // Behavioural reference: tracks cycles since accept and commits the
    // arithmetic answer 2*LAT+1 edges after the accept edge.
    logic        m_active, m_done, m_hold;
    int          m_age;
    logic [1:0]  m_op;
    logic [15:0] m_a, m_b, m_res;
    logic [3:0]  m_flags, m_we;
    logic [23:0] m_ref_s;
    logic [16:0] m_alu_s;
    logic        m_alu_en_s;
    assign m_ref_s    = ref_op(m_op, m_a, m_b, m_flags);
    assign m_alu_s    = exp_alu(m_op, m_a, m_b, m_age >= LAT);
    assign m_alu_en_s = m_active && (m_age < 2 * LAT);

    always @(posedge clk) begin
      if (!nreset_a[g]) begin
        m_active <= 1'b0; m_done <= 1'b0; m_hold <= 1'b1; m_age <= 0;
        m_res <= 16'h0000; m_flags <= 4'h0; m_we <= 4'h0;
      end else if (m_active) begin
        if (m_age == 2 * LAT) begin
          m_active <= 1'b0; m_done <= 1'b1;
          m_res <= m_ref_s[23:8]; m_flags <= m_ref_s[7:4]; m_we <= m_ref_s[3:0];
        end else begin
          m_age <= m_age + 1; m_done <= 1'b0;
        end
      end else begin
        m_done <= 1'b0;
        if (start_a[g]) begin
          m_active <= 1'b1; m_age <= 0; m_hold <= 1'b0;
          m_op <= op_a[g]; m_a <= opa_a[g]; m_b <= opb_a[g];
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en_a[g]) begin
        chk(LAT, "busy", 32'(busy_s), 32'(m_active));
        chk(LAT, "done", 32'(done_s), 32'(m_done));
        chk(LAT, "alu_en", 32'(alu_en_s), 32'(m_alu_en_s));
        chk(LAT, "result", 32'(result_s), 32'(m_res));
        chk(LAT, "flags", 32'(flags_s), 32'(m_flags));
        if (m_done) chk(LAT, "flags_we", 32'(fwe_s), 32'(m_we));
        if (m_alu_en_s) chk(LAT, "alu {a,b,cin}", 32'({alu_a_s, alu_b_s, alu_cin_s}), 32'(m_alu_s));
        if (m_hold && !m_active)
          chk(LAT, "post-reset we/alu", 32'({fwe_s, alu_a_s, alu_b_s, alu_cin_s}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int idx, input int lat, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef,
                        input logic [3:0] ew);
    int  n;
    bit  seen;
    start_a[idx] = 1'b1; op_a[idx] = op; opa_a[idx] = a; opb_a[idx] = b;
    tick();
    start_a[idx] = 1'b0;
    n = 99; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      tick();
      if (done_a[idx]) begin seen = 1'b1; n = k; end
    end
    chk(lat, $sformatf("op%0d %h,%h latency", op, a, b), 32'(n), 32'(2 * lat + 1));
    chk(lat, $sformatf("op%0d %h,%h result", op, a, b), 32'(result_a[idx]), 32'(er));
    chk(lat, $sformatf("op%0d %h,%h flags", op, a, b), 32'(flags_a[idx]), 32'(ef));
    chk(lat, $sformatf("op%0d %h,%h flags_we", op, a, b), 32'(fwe_a[idx]), 32'(ew));
  endtask

  task automatic run_all(input int idx, input int lat);
    int dn;
    int p;
    p = 2 * lat + 2;
    chk_en_a[idx] = 1'b0;
    nreset_a[idx] = 1'b0; start_a[idx] = 1'b0; op_a[idx] = 2'd0;
    opa_a[idx] = 16'h0000; opb_a[idx] = 16'h0000;
    repeat (3) tick();
    chk_en_a[idx] = 1'b1;
    chk(lat, "reset busy/done/alu_en", 32'({busy_a[idx], done_a[idx], alu_en_a[idx]}), 32'd0);
    chk(lat, "reset result/flags/we", 32'({result_a[idx], flags_a[idx], fwe_a[idx]}), 32'd0);
    chk(lat, "reset alu drive", 32'(aluop_a[idx]), 32'd0);
    nreset_a[idx] = 1'b1;
    tick();

    run_op(idx, lat, 2'b00, 16'h0FFF, 16'h0001, 16'h1000, 4'b0010, 4'b0111);
    run_op(idx, lat, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 4'b0111);
    run_op(idx, lat, 2'b00, 16'h7777, 16'h7777, 16'hEEEE, 4'b0000, 4'b0111);
    run_op(idx, lat, 2'b01, 16'h0000, 16'h00FF, 16'hFFFF, 4'b0000, 4'b1111);
    run_op(idx, lat, 2'b01, 16'h00FF, 16'h0001, 16'h0100, 4'b0011, 4'b1111);
    run_op(idx, lat, 2'b10, 16'hFFFF, 16'hA5A5, 16'h0000, 4'b0011, 4'b0000);
    run_op(idx, lat, 2'b11, 16'h0000, 16'h5A5A, 16'hFFFF, 4'b0011, 4'b0000);

    // start held high from idle: one op per 2*LAT+2 cycles.
    dn = 0;
    start_a[idx] = 1'b1; op_a[idx] = 2'b00; opa_a[idx] = 16'h1234; opb_a[idx] = 16'h4321;
    for (int k = 0; k < 3 * p; k++) begin
      tick();
      if (done_a[idx]) dn++;
    end
    start_a[idx] = 1'b0;
    for (int k = 0; k < 3 * p; k++) begin
      tick();
      if (done_a[idx]) dn++;
    end
    chk(lat, "start-every-cycle done count", 32'(dn), 32'd3);

    // Reset during the HI phase.
    start_a[idx] = 1'b1; op_a[idx] = 2'b01; opa_a[idx] = 16'h8F0F; opb_a[idx] = 16'h0081;
    tick();
    start_a[idx] = 1'b0;
    repeat (lat) tick();
    nreset_a[idx] = 1'b0;
    tick();
    nreset_a[idx] = 1'b1;
    chk(lat, "HI reset busy/done/alu_en", 32'({busy_a[idx], done_a[idx], alu_en_a[idx]}), 32'd0);
    chk(lat, "HI reset result/flags/we", 32'({result_a[idx], flags_a[idx], fwe_a[idx]}), 32'd0);
    dn = 0;
    for (int k = 0; k < 3 * p; k++) begin
      tick();
      if (done_a[idx]) dn++;
    end
    chk(lat, "HI reset no done", 32'(dn), 32'd0);

    // Random traffic, including starts while busy.
    for (int k = 0; k < 400; k++) begin
      start_a[idx] = ($urandom_range(0, 2) == 0);
      op_a[idx]    = 2'($urandom_range(0, 3));
      opa_a[idx]   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      opb_a[idx]   = 16'($urandom);
      tick();
    end
    start_a[idx] = 1'b0;
    repeat (2 * p) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      run_all(0, 1);
      run_all(1, 3);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
